bsg_arb_mux_one_hot_rr: RTL and testbench
=========================================

Name: bsg_arb_mux_one_hot_rr

Overview:
- Round-robin, packet-aware arbiter that shares one one-hot AND-OR datapath mux between els_p valid/ready requesters.
- Drives the mux select as a one-hot grant and registers the muxed beat in a one-entry output stage with a v_o/yumi_i interface.
- Sits in front of shared 62-bit return/response paths where two producers feed one consumer and multi-beat packets must not interleave.

Parameters:
- width_p, 62, data width per requester and of data_o.
- els_p, 2, number of requesters; legal range 2..8.

Ports:
- clk_i  in  1  single clock.
- reset_i  in  1  asynchronous, active-high reset.
- v_i  in  els_p  per-requester valid.
- data_i  in  els_p*width_p  requester k occupies bits [k*width_p +: width_p].
- last_i  in  els_p  per-requester end-of-packet flag for the current beat.
- ready_o  out  els_p  per-requester accept; a beat transfers when v_i[k] & ready_o[k].
- v_o  out  1  output entry valid.
- data_o  out  width_p  registered muxed data.
- last_o  out  1  registered last flag.
- yumi_i  in  1  consumer dequeues the output entry this cycle.
- sel_one_hot_o  out  els_p  current grant, also the mux select.
- lock_o  out  1  arbiter is locked to one requester mid-packet.

Behaviour:
- Reset is asynchronous: v_o=0, data_o=0, last_o=0, lock_o=0, state=IDLE, priority pointer=els_p-1 (requester 0 wins first).
- enq_ok = ~v_o | yumi_i. ready_o[k] = enq_ok & grant[k]. ready_o is never asserted for a requester with no grant.
- Grant is zero-or-one-hot and never has two bits set. sel_one_hot_o = grant. The grant is combinational from v_i and the state.
- IDLE: grant = first requester with v_i set, scanning k = ptr+1, ptr+2, … modulo els_p. If no v_i is set, grant=0.
- LOCKED: grant = onehot(lock_id) & v_i. Other requesters are ignored even when valid. lock_o=1.
- Accept in IDLE with last_i=0: go to LOCKED, lock_id=k.
- Accept in IDLE with last_i=1: stay IDLE, ptr=k.
- Accept in LOCKED with last_i=1: go to IDLE, ptr=lock_id.
- Accept in LOCKED with last_i=0: stay LOCKED.
- ptr updates only at packet end, so a packet counts as one round-robin turn.
- Datapath: muxed = AND-OR of data_i slices by grant.
- On accept: data_o<=muxed, last_o<=last_i[k], v_o<=1.
- On yumi_i without an accept: v_o<=0. data_o and last_o hold their values.
- Latency is 1 cycle from accept to v_o.
- Throughput is 1 beat per cycle when yumi_i is held high; a dequeue and an enqueue in the same cycle are legal.
- Backpressure: while v_o=1 and yumi_i=0, ready_o=0 and data_o is stable.
- Requester rules: once v_i[k] is high, it stays high with data stable until accepted.
- Consumer rule: yumi_i=1 with v_o=0 is illegal; the implementation must include an assertion for it.
- Reset mid-packet: the lock and the output entry are cleared immediately. A partially sent packet is dropped; requesters are reset in the same domain.
- A locked requester dropping v_i mid-packet stalls the arbiter; this is legal and the lock is held.

Decomposition:
- No shared package is needed.
- The local state enum {IDLE, LOCKED} is defined in the module. The lock_id and ptr width is $clog2(els_p).
- Sub-module: bsg_mux_one_hot, instantiated with width_p and els_p, fed by grant.
- Arbiter logic and the output register stay inline.

Test Plan:
- Reset: hold reset_i=1, then release with v_i=0 → v_o=0, ready_o=2'b00, sel_one_hot_o=2'b00, lock_o=0.
- Fairness: v_i=2'b11 and last_i=2'b11 continuously, data_i[0]=0xA, data_i[1]=0xB, yumi_i=1 → data_o sequence A,B,A,B starting one cycle after the first accept.
- Packet lock: requester 1 sends a 3-beat packet (0x11, 0x12, 0x13 with last on beat 3) while v_i[0]=1 → data_o = 0x11, 0x12, 0x13, then requester 0's beat; lock_o=1 for beats 1-2.
- Backpressure: v_o=1 with yumi_i=0 for 4 cycles → data_o unchanged and ready_o=0. Then yumi_i=1 → new accept in the same cycle, next data_o shows on the following cycle.
- Async reset mid-packet: assert reset_i mid-cycle while lock_o=1 → v_o and lock_o fall without a clock edge. After release, requester 0 wins first.
- Single requester: only v_i[1]=1 with single-beat packets and yumi_i=1 → one beat per cycle, sel_one_hot_o=2'b10 throughout.

Source files
------------

// File: rtl/bsg_mux_one_hot.sv
// One-hot AND-OR mux: each input slice is gated by its select bit and the
// results are ORed together. A zero select yields zero.
module bsg_mux_one_hot #(
  parameter int width_p = 62,
  parameter int els_p   = 2
) (
  input  logic [els_p*width_p-1:0] data_i,
  input  logic [els_p-1:0]         sel_one_hot_i,
  output logic [width_p-1:0]       data_o
);

  always_comb begin
    data_o = '0;
    for (int k = 0; k < els_p; k++) begin
      data_o = data_o | (data_i[k*width_p +: width_p] & {width_p{sel_one_hot_i[k]}});
    end
  end

endmodule

// File: rtl/bsg_arb_mux_one_hot_rr.sv
// Packet-aware round-robin arbiter driving a shared one-hot mux into a
// one-entry registered output stage (v_o/yumi_i).
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | no packet in flight; grant by round-robin after ptr_q
// LOCKED | mid-packet; only lock_id_q may transfer until its last beat
module bsg_arb_mux_one_hot_rr #(
  parameter int width_p = 62,
  parameter int els_p   = 2
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic [els_p-1:0]         v_i,
  input  logic [els_p*width_p-1:0] data_i,
  input  logic [els_p-1:0]         last_i,
  output logic [els_p-1:0]         ready_o,
  output logic                     v_o,
  output logic [width_p-1:0]       data_o,
  output logic                     last_o,
  input  logic                     yumi_i,
  output logic [els_p-1:0]         sel_one_hot_o,
  output logic                     lock_o
);

  localparam int id_w = $clog2(els_p);

  typedef enum logic {IDLE, LOCKED} state_e;

  state_e            state_q, state_n;
  logic [id_w-1:0]   lock_id_q, lock_id_n;
  logic [id_w-1:0]   ptr_q, ptr_n;
  logic [els_p-1:0]  grant;
  logic [id_w-1:0]   grant_id;
  logic [id_w-1:0]   scan_id;
  logic              found;
  logic              enq_ok;
  logic              accept;
  logic              last_sel;
  logic [width_p-1:0] muxed;

  // Grant is purely combinational from v_i and the arbiter state.
  always_comb begin
    grant   = '0;
    found   = 1'b0;
    scan_id = '0;
    if (state_q == LOCKED) begin
      for (int k = 0; k < els_p; k++) begin
        grant[k] = v_i[k] & (lock_id_q == id_w'(k));
      end
    end else begin
      for (int i = 1; i <= els_p; i++) begin
        scan_id = id_w'((int'(ptr_q) + i) % els_p);
        if (!found && v_i[scan_id]) begin
          grant[scan_id] = 1'b1;
          found          = 1'b1;
        end
      end
    end
  end

  always_comb begin
    grant_id = '0;
    for (int k = 0; k < els_p; k++) begin
      if (grant[k]) grant_id = id_w'(k);
    end
  end

  assign enq_ok        = ~v_o | yumi_i;
  assign ready_o       = grant & {els_p{enq_ok}};
  assign accept        = |(v_i & ready_o);
  assign last_sel      = |(last_i & grant);
  assign sel_one_hot_o = grant;

  bsg_mux_one_hot #(
    .width_p(width_p),
    .els_p  (els_p)
  ) mux (
    .data_i       (data_i),
    .sel_one_hot_i(grant),
    .data_o       (muxed)
  );

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q   <= IDLE;
      lock_id_q <= '0;
      ptr_q     <= id_w'(els_p - 1);
    end else begin
      state_q   <= state_n;
      lock_id_q <= lock_id_n;
      ptr_q     <= ptr_n;
    end
  end

  // The pointer only moves at packet end so a whole packet is one turn.
  always_comb begin
    state_n   = state_q;
    lock_id_n = lock_id_q;
    ptr_n     = ptr_q;
    if (accept) begin
      case (state_q)
        IDLE: begin
          if (last_sel) begin
            ptr_n = grant_id;
          end else begin
            state_n   = LOCKED;
            lock_id_n = grant_id;
          end
        end
        LOCKED: begin
          if (last_sel) begin
            state_n = IDLE;
            ptr_n   = lock_id_q;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  always_comb begin
    lock_o = (state_q == LOCKED);
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      v_o    <= 1'b0;
      data_o <= '0;
      last_o <= 1'b0;
    end else if (accept) begin
      v_o    <= 1'b1;
      data_o <= muxed;
      last_o <= last_sel;
    end else if (yumi_i) begin
      v_o <= 1'b0;
    end
  end

  yumi_only_when_valid: assert property (@(posedge clk_i) disable iff (reset_i) !(yumi_i && !v_o));
  grant_zero_or_one_hot: assert property (@(posedge clk_i) disable iff (reset_i) $onehot0(grant));

endmodule

// File: tb/tb_bsg_arb_mux_one_hot_rr.sv
// Directed and randomized checks of the round-robin packet arbiter against
// a behavioural model of grants, packet locks and the output entry.
module tb_bsg_arb_mux_one_hot_rr;

  localparam int W  = 62;
  localparam int EL = 2;

  logic              clk_i;
  logic              reset_i;
  logic [EL-1:0]     v_i;
  logic [EL*W-1:0]   data_i;
  logic [EL-1:0]     last_i;
  logic [EL-1:0]     ready_o;
  logic              v_o;
  logic [W-1:0]      data_o;
  logic              last_o;
  logic              yumi_i;
  logic [EL-1:0]     sel_one_hot_o;
  logic              lock_o;

  int total = 0;
  int bad   = 0;

  // behavioural model state
  bit            m_v;
  logic [W-1:0]  m_data;
  bit            m_last;
  bit            m_locked;
  int            m_owner;
  int            m_ptr;
  logic [EL-1:0] m_g;
  logic [EL-1:0] m_ready;
  logic [EL-1:0] m_acc;
  bit            yumi_en;

  bsg_arb_mux_one_hot_rr #(.width_p(W), .els_p(EL)) dut (
    .clk_i        (clk_i),
    .reset_i      (reset_i),
    .v_i          (v_i),
    .data_i       (data_i),
    .last_i       (last_i),
    .ready_o      (ready_o),
    .v_o          (v_o),
    .data_o       (data_o),
    .last_o       (last_o),
    .yumi_i       (yumi_i),
    .sel_one_hot_o(sel_one_hot_o),
    .lock_o       (lock_o)
  );

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_data(input int k, input logic [W-1:0] d);
    data_i[k*W +: W] = d;
  endtask

  task automatic model_reset();
    m_v = 0; m_data = '0; m_last = 0; m_locked = 0; m_owner = 0; m_ptr = EL - 1;
    m_acc = '0;
  endtask

  // Grant: locked owner if it is valid, else first valid after the pointer.
  task automatic model_comb();
    m_g = '0;
    if (m_locked) begin
      if (v_i[m_owner]) m_g[m_owner] = 1'b1;
    end else begin
      for (int i = 1; i <= EL; i++) begin
        int j;
        j = (m_ptr + i) % EL;
        if (v_i[j]) begin
          m_g[j] = 1'b1;
          break;
        end
      end
    end
    m_ready = (!m_v || yumi_i) ? m_g : '0;
  endtask

  task automatic model_update();
    int k;
    m_acc = v_i & m_ready;
    k = -1;
    for (int i = 0; i < EL; i++) if (m_acc[i]) k = i;
    if (k >= 0) begin
      m_v    = 1;
      m_data = data_i[k*W +: W];
      m_last = last_i[k];
      if (!m_locked) begin
        if (last_i[k]) m_ptr = k;
        else begin m_locked = 1; m_owner = k; end
      end else if (last_i[k]) begin
        m_locked = 0;
        m_ptr    = m_owner;
      end
    end else if (yumi_i) begin
      m_v = 0;
    end
  endtask

  // Inputs are set before the call; checks at negedge, model advances at posedge.
  task automatic step();
    yumi_i = yumi_en & m_v;
    @(negedge clk_i);
    model_comb();
    chk("sel", 64'(sel_one_hot_o), 64'(m_g));
    chk("ready", 64'(ready_o), 64'(m_ready));
    chk("lock", 64'(lock_o), 64'(m_locked));
    chk("v_o", 64'(v_o), 64'(m_v));
    if (m_v) begin
      chk("data_o", 64'(data_o), 64'(m_data));
      chk("last_o", 64'(last_o), 64'(m_last));
    end
    @(posedge clk_i);
    model_update();
    #1;
  endtask

  initial begin
    logic [W-1:0] d;
    reset_i = 1'b1; v_i = '0; data_i = '0; last_i = '0; yumi_i = 1'b0; yumi_en = 1'b0;
    model_reset();

    // reset state
    #12;
    chk("rst_v_o", 64'(v_o), 64'd0);
    chk("rst_lock", 64'(lock_o), 64'd0);
    @(posedge clk_i); #1;
    reset_i = 1'b0;
    step();
    chk("rst_ready", 64'(ready_o), 64'd0);
    chk("rst_sel", 64'(sel_one_hot_o), 64'd0);

    // fairness: alternate A,B with single-beat packets
    v_i = 2'b11; last_i = 2'b11; set_data(0, 62'hA); set_data(1, 62'hB); yumi_en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("fair_data", 64'(data_o), (i % 2 == 0) ? 64'hA : 64'hB);
    end

    // packet lock: requester 1 sends three beats while requester 0 waits
    last_i = 2'b01; set_data(0, 62'h0C); set_data(1, 62'h11);
    step();
    chk("pkt_b1", 64'(data_o), 64'h11);
    chk("pkt_lock1", 64'(lock_o), 64'd1);
    set_data(1, 62'h12);
    step();
    chk("pkt_b2", 64'(data_o), 64'h12);
    chk("pkt_lock2", 64'(lock_o), 64'd1);
    set_data(1, 62'h13); last_i = 2'b11;
    step();
    chk("pkt_b3", 64'(data_o), 64'h13);
    chk("pkt_unlock", 64'(lock_o), 64'd0);
    v_i = 2'b01;
    step();
    chk("pkt_after", 64'(data_o), 64'h0C);

    // backpressure: entry held, no accepts, then same-cycle deq/enq
    yumi_en = 1'b0; set_data(0, 62'h22);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("bp_hold", 64'(data_o), 64'h0C);
      chk("bp_ready", 64'(ready_o), 64'd0);
    end
    yumi_en = 1'b1;
    step();
    chk("bp_release", 64'(data_o), 64'h22);

    // asynchronous reset mid-packet
    v_i = 2'b10; last_i = 2'b00; set_data(1, 62'h33);
    step();
    chk("mid_lock", 64'(lock_o), 64'd1);
    v_i = 2'b00; yumi_i = 1'b0;
    #2 reset_i = 1'b1;
    #1;
    chk("async_v_o", 64'(v_o), 64'd0);
    chk("async_lock", 64'(lock_o), 64'd0);
    model_reset();
    @(posedge clk_i); #1;
    reset_i = 1'b0;
    v_i = 2'b11; last_i = 2'b11; set_data(0, 62'h40); set_data(1, 62'h41);
    step();
    chk("post_rst_first", 64'(data_o), 64'h40);

    // single requester streaming
    v_i = 2'b10;
    for (int i = 0; i < 4; i++) begin
      set_data(1, W'(64'h50 + 64'(i)));
      step();
      chk("single_sel", 64'(sel_one_hot_o), 64'h2);
      chk("single_data", 64'(data_o), 64'h50 + 64'(i));
    end

    // randomized traffic obeying requester hold rules
    for (int n = 0; n < 400; n++) begin
      for (int k = 0; k < EL; k++) begin
        if (!v_i[k] || m_acc[k]) begin
          v_i[k]    = ($urandom_range(0, 3) != 0);
          d         = W'({$urandom(), $urandom()});
          set_data(k, d);
          last_i[k] = ($urandom_range(0, 2) == 0);
        end
      end
      yumi_en = ($urandom_range(0, 3) != 0);
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
